pixel_queue: RTL and testbench
==============================

Name: pixel_queue

Overview:
- Elastic buffer between packet_generator (brush/symmetry expansion, one pixel per cycle) and the slow I2C slave readout.
- Captures each {colour, y, x} pixel on pkt_valid and drops consecutive duplicates.
- Presents the oldest pixel first-word-fall-through to the host-read side and reports occupancy and loss.

Parameters:
- ADDR_W, 4, log2 of queue depth; DEPTH = 2**ADDR_W = 16 entries.
- DEDUP, 1, 1 = discard a push identical to the last accepted push; 0 = accept all pushes.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous clear of queue contents and dedup history; counters kept
- push  in  1  pixel strobe (pkt_valid)
- x_in  in  8  pixel x
- y_in  in  8  pixel y
- color_in  in  3  pixel colour {R,G,B}
- pop  in  1  host consumed head entry (one-cycle pulse from I2C slave after a read completes)
- head_valid  out  1  queue non-empty; head_* meaningful
- head_x  out  8  oldest entry x
- head_y  out  8  oldest entry y
- head_color  out  3  oldest entry colour
- count  out  ADDR_W+1  entries held, 0..DEPTH
- full  out  1  count == DEPTH
- drop_cnt  out  8  pushes lost to full queue, saturates at 255
- overflow  out  1  sticky: at least one push dropped since reset
- underflow  out  1  sticky: pop seen while empty

Behaviour:
- Storage: DEPTH x 19-bit array, entry = {color, y, x}. Write and read pointers are ADDR_W bits and wrap modulo DEPTH. count is a separate register; empty/full are derived from count.
- Reset (rst=1 at a clk edge), applies to all outputs:
  - count=0, pointers=0, head_valid=0, full=0.
  - head_x/head_y/head_color=0 while empty, by gating the array output.
  - drop_cnt=0, overflow=0, underflow=0, dedup history invalid.
  - Array contents are not reset.
- Reset dominates flush, push and pop in the same cycle.
- Flush:
  - Next cycle count=0, pointers=0, dedup history invalid.
  - drop_cnt, overflow and underflow are unchanged.
  - Flush dominates push and pop in the same cycle.
- Dedup, when DEDUP=1:
  - Registers last_x/last_y/last_col/last_valid track the most recently accepted push.
  - A push whose {color,y,x} equals the last one while last_valid=1 is discarded silently: no count change, no drop_cnt change.
  - History is independent of pops; a drained queue still dedups against the last accepted pixel.
- Accept: push=1, not a duplicate, and (count<DEPTH or pop accepted this cycle). The entry is written at wr_ptr, wr_ptr advances, and the dedup history is updated.
- Drop:
  - Condition: push=1, not a duplicate, count==DEPTH and no pop this cycle.
  - Effect: drop_cnt+1 (saturating at 255), overflow=1. The dedup history is NOT updated, so a retry of the same pixel is not suppressed.
- Pop:
  - Condition: pop=1 and count>0. rd_ptr advances.
  - pop=1 with count==0 sets underflow and has no other effect.
- Simultaneous accepted push and pop: count unchanged, both pointers advance. This also holds when full (pop frees the slot) and when count==1.
- Push into an empty queue is never bypassed: the entry appears on head_* with head_valid=1 one cycle after the push edge (latency 1).
- Head outputs are combinational from array[rd_ptr]. They are stable while no pop occurs.
- count update per cycle: +1 on accept only, -1 on pop only, 0 otherwise. Result is always in 0..DEPTH.

Test Plan:
- Reset, then push {x=5,y=9,col=3'b100} once -> next cycle head_valid=1, head_x=5, head_y=9, head_color=4, count=1; pop -> next cycle count=0, head_valid=0, head_*=0.
- 17 distinct pushes (x=0..16, y=0) with no pops -> count=16, full=1, drop_cnt=1, overflow=1; 16 pops return x=0..15 in order, then head_valid=0; pointer wrap verified by 8 more push/pop pairs reading back correctly.
- Full queue, push x=99 with pop in the same cycle -> count stays 16, drop_cnt unchanged, x=99 emerges as the 16th entry after the popped one.
- DEDUP=1: push (3,3,1) three consecutive cycles, then (4,3,1), then (3,3,1) -> count=3; drain, then push (3,3,1) -> discarded, count=0 (history survives drain); flush, then push (3,3,1) -> count=1.
- Pop on empty queue -> underflow=1, count=0, pointers unchanged; flush -> underflow remains 1; rst -> underflow=0, drop_cnt=0.
- Push, pop and flush in the same cycle with count=5 -> next cycle count=0; push with rst=1 -> count=0, overflow=0.

Source files
------------

// File: rtl/pixel_queue.sv
// Elastic FIFO between the packet generator and the I2C readout: dedups consecutive
// identical pixels, presents the oldest entry first-word-fall-through, tracks loss.
module pixel_queue #(
    parameter int ADDR_W = 4,
    parameter bit DEDUP  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic [7:0]        x_in,
    input  logic [7:0]        y_in,
    input  logic [2:0]        color_in,
    input  logic              pop,
    output logic              head_valid,
    output logic [7:0]        head_x,
    output logic [7:0]        head_y,
    output logic [2:0]        head_color,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic [7:0]        drop_cnt,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [18:0]       mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic [18:0]       last_q, last_d;
    logic              last_valid_q, last_valid_d;

    logic [18:0] entry, rd_entry;
    logic        is_dup, not_full, is_empty, do_pop, do_push, do_drop;

    always_comb begin
        entry    = {color_in, y_in, x_in};
        is_empty = (count_q == '0);
        not_full = (count_q != FULL_CNT);
        is_dup   = DEDUP && last_valid_q && (entry == last_q);
        do_pop   = pop && !is_empty;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        do_push  = push && !is_dup && (not_full || do_pop);
        do_drop  = push && !is_dup && !not_full && !do_pop;
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        drop_cnt_d   = drop_cnt_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        last_d       = last_q;
        last_valid_d = last_valid_q;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            count_d      = '0;
            last_valid_d = 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_d     = wr_ptr_q + 1'b1;
                last_d       = entry;
                last_valid_d = 1'b1;
            end
            if (do_pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (pop && is_empty)
                underflow_d = 1'b1;
            if (do_drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 8'hFF)
                    drop_cnt_d = drop_cnt_q + 8'd1;
            end
            if (do_push && !do_pop)
                count_d = count_q + 1'b1;
            else if (do_pop && !do_push)
                count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            drop_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            last_q       <= '0;
            last_valid_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            drop_cnt_q   <= drop_cnt_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            last_q       <= last_d;
            last_valid_q <= last_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push)
            mem_q[wr_ptr_q] <= entry;
    end

    always_comb begin
        rd_entry   = is_empty ? '0 : mem_q[rd_ptr_q];
        head_valid = !is_empty;
        head_x     = rd_entry[7:0];
        head_y     = rd_entry[15:8];
        head_color = rd_entry[18:16];
        count      = count_q;
        full       = !not_full;
        drop_cnt   = drop_cnt_q;
        overflow   = overflow_q;
        underflow  = underflow_q;
    end
endmodule

// File: tb/tb_pixel_queue.sv
// Bench for pixel_queue: queue-based reference model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_pixel_queue;
    logic       clk = 1'b0;
    logic       rst, flush, push, pop;
    logic [7:0] x_in, y_in;
    logic [2:0] color_in;
    logic       head_valid, full, overflow, underflow;
    logic [7:0] head_x, head_y, drop_cnt;
    logic [2:0] head_color;
    logic [4:0] count;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    pixel_queue #(.ADDR_W(4), .DEDUP(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush), .push(push),
        .x_in(x_in), .y_in(y_in), .color_in(color_in), .pop(pop),
        .head_valid(head_valid), .head_x(head_x), .head_y(head_y),
        .head_color(head_color), .count(count), .full(full),
        .drop_cnt(drop_cnt), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue plus the last accepted pixel.
    logic [18:0] mq[$];
    logic [18:0] m_last;
    bit          m_lv;
    int          m_drop;
    bit          m_ovf, m_udf;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete(); m_lv = 0; m_drop = 0; m_ovf = 0; m_udf = 0;
        end else if (flush) begin
            mq.delete(); m_lv = 0;
        end else begin
            logic [18:0] e;
            bit dup, popok, room;
            e     = {color_in, y_in, x_in};
            dup   = m_lv && (e == m_last);
            popok = pop && (mq.size() > 0);
            room  = (mq.size() < 16) || popok;
            if (pop && mq.size() == 0) m_udf = 1;
            if (popok) void'(mq.pop_front());
            if (push && !dup) begin
                if (room) begin
                    mq.push_back(e); m_last = e; m_lv = 1;
                end else begin
                    m_ovf = 1;
                    if (m_drop < 255) m_drop++;
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [18:0] h;
            h = (mq.size() > 0) ? mq[0] : 19'd0;
            chk("m.head_valid", int'(head_valid), int'(mq.size() > 0));
            chk("m.head_x", int'(head_x), int'(h[7:0]));
            chk("m.head_y", int'(head_y), int'(h[15:8]));
            chk("m.head_color", int'(head_color), int'(h[18:16]));
            chk("m.count", int'(count), mq.size());
            chk("m.full", int'(full), int'(mq.size() == 16));
            chk("m.drop_cnt", int'(drop_cnt), m_drop);
            chk("m.overflow", int'(overflow), int'(m_ovf));
            chk("m.underflow", int'(underflow), int'(m_udf));
        end
    end

    task automatic step(input bit r, input bit fl, input bit p, input int x, input int y,
                        input int c, input bit pp);
        rst = r; flush = fl; push = p; pop = pp;
        x_in = 8'(x); y_in = 8'(y); color_in = 3'(c);
        @(posedge clk);
        #1;
        rst = 0; flush = 0; push = 0; pop = 0;
    endtask

    task automatic do_rst();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; flush = 0; push = 0; pop = 0; x_in = 0; y_in = 0; color_in = 0;
        do_rst();
        chk_en = 1'b1;
        chk("rst.count", int'(count), 0);
        chk("rst.head_valid", int'(head_valid), 0);

        // Single push/pop with latency 1
        step(0, 0, 1, 5, 9, 4, 0);
        chk("t1.head_valid", int'(head_valid), 1);
        chk("t1.head_x", int'(head_x), 5);
        chk("t1.head_y", int'(head_y), 9);
        chk("t1.head_color", int'(head_color), 4);
        chk("t1.count", int'(count), 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("t1.count0", int'(count), 0);
        chk("t1.hv0", int'(head_valid), 0);
        chk("t1.hx0", int'(head_x), 0);

        // Overfill, drain in order, then wrap
        do_rst();
        for (int i = 0; i < 17; i++) step(0, 0, 1, i, 0, 0, 0);
        chk("t2.count", int'(count), 16);
        chk("t2.full", int'(full), 1);
        chk("t2.drop", int'(drop_cnt), 1);
        chk("t2.ovf", int'(overflow), 1);
        for (int i = 0; i < 16; i++) begin
            chk("t2.order", int'(head_x), i);
            step(0, 0, 0, 0, 0, 0, 1);
        end
        chk("t2.empty", int'(head_valid), 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, 100 + i, 1, 2, 0);
            chk("t2.wrap", int'(head_x), 100 + i);
            step(0, 0, 0, 0, 0, 0, 1);
        end

        // Full queue: push with simultaneous pop
        do_rst();
        for (int i = 0; i < 16; i++) step(0, 0, 1, i, 0, 0, 0);
        step(0, 0, 1, 99, 0, 0, 1);
        chk("t3.count", int'(count), 16);
        chk("t3.drop", int'(drop_cnt), 0);
        for (int i = 1; i < 16; i++) begin
            chk("t3.order", int'(head_x), i);
            step(0, 0, 0, 0, 0, 0, 1);
        end
        chk("t3.x99", int'(head_x), 99);

        // Dedup history
        do_rst();
        for (int i = 0; i < 3; i++) step(0, 0, 1, 3, 3, 1, 0);
        step(0, 0, 1, 4, 3, 1, 0);
        step(0, 0, 1, 3, 3, 1, 0);
        chk("t4.count3", int'(count), 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 3, 3, 1, 0);
        chk("t4.dup_after_drain", int'(count), 0);
        step(0, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 3, 1, 0);
        chk("t4.after_flush", int'(count), 1);

        // Underflow stickiness
        do_rst();
        step(0, 0, 0, 0, 0, 0, 1);
        chk("t5.udf", int'(underflow), 1);
        chk("t5.count", int'(count), 0);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("t5.udf_flush", int'(underflow), 1);
        do_rst();
        chk("t5.udf_rst", int'(underflow), 0);
        chk("t5.drop_rst", int'(drop_cnt), 0);

        // Flush and reset priority
        for (int i = 0; i < 5; i++) step(0, 0, 1, 20 + i, 0, 0, 0);
        step(0, 1, 1, 50, 0, 0, 1);
        chk("t6.flush", int'(count), 0);
        step(1, 0, 1, 51, 0, 0, 0);
        chk("t6.rst_push", int'(count), 0);
        chk("t6.rst_ovf", int'(overflow), 0);

        // Randomized traffic over a small value space so duplicates are common
        for (int i = 0; i < 3000; i++) begin
            bit r, fl, p, pp;
            r  = ($urandom_range(0, 399) == 0);
            fl = ($urandom_range(0, 99) == 0);
            p  = ($urandom_range(0, 99) < 65);
            pp = ($urandom_range(0, 99) < ((i / 500) % 2 ? 55 : 30));
            step(r, fl, p, $urandom_range(0, 3), $urandom_range(0, 1),
                 $urandom_range(0, 1), pp);
        end
        step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
